// File: rtl/ff_layer_pkg.sv
// rtl/ff_layer_pkg.sv - shared types, constants and address helper for the layer controller
package ff_layer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        WAIT,
        WRITE,
        DONE
    } state_t;

    localparam logic [31:0] ZERO = 32'h0000_0000;

    // Each node owns a row of n_in weights followed by its bias.
    function automatic logic [31:0] weight_addr(
        input logic [31:0] node,
        input logic [31:0] beat,
        input logic [31:0] n_in
    );
        return node * (n_in + 32'd1) + beat;
    endfunction

endpackage

// File: rtl/feed_forward_layer_controller.sv
// rtl/feed_forward_layer_controller.sv - sequences one fully connected layer through a single node
module feed_forward_layer_controller
    import ff_layer_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int ADDRESS_WIDTH         = 5,
    parameter int NUMBER_OF_INPUT_NODE  = 2,
    parameter int NUMBER_OF_OUTPUT_NODE = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error,
    output logic                     o_data_rd,
    output logic [ADDRESS_WIDTH-1:0] o_data_addr,
    input  logic [DATA_WIDTH-1:0]    i_data_ram,
    output logic                     o_weight_rd,
    output logic [ADDRESS_WIDTH-1:0] o_weight_addr,
    input  logic [DATA_WIDTH-1:0]    i_weight_ram,
    output logic                     o_node_valid,
    output logic [DATA_WIDTH-1:0]    o_node_data,
    output logic [DATA_WIDTH-1:0]    o_node_weight,
    input  logic                     i_node_valid,
    input  logic [DATA_WIDTH-1:0]    i_node_data,
    output logic                     o_result_we,
    output logic [ADDRESS_WIDTH-1:0] o_result_addr,
    output logic [DATA_WIDTH-1:0]    o_result_data
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_BEAT = ADDRESS_WIDTH'(NUMBER_OF_INPUT_NODE);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_NODE = ADDRESS_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);
    localparam logic [DATA_WIDTH-1:0]    FP_ZERO   = DATA_WIDTH'(ZERO);

    if (NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_INPUT_NODE + 1) > (1 << ADDRESS_WIDTH)) begin : g_size_check
        $error("weight table does not fit in ADDRESS_WIDTH");
    end

    state_t                   state;
    state_t                   next_state;
    logic [ADDRESS_WIDTH-1:0] node_idx;
    logic [ADDRESS_WIDTH-1:0] beat_idx;
    logic                     beat_valid_d;
    logic                     input_beat_d;
    logic [DATA_WIDTH-1:0]    result_q;
    logic                     error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        o_data_rd     = 1'b0;
        o_data_addr   = '0;
        o_weight_rd   = 1'b0;
        o_weight_addr = '0;
        o_result_we   = 1'b0;
        o_result_addr = '0;
        o_result_data = '0;
        case (state)
            IDLE: begin
                if (i_start) next_state = LOAD;
            end
            LOAD: begin
                o_busy        = 1'b1;
                o_weight_rd   = 1'b1;
                o_weight_addr = ADDRESS_WIDTH'(weight_addr(32'(node_idx), 32'(beat_idx),
                                                           32'(NUMBER_OF_INPUT_NODE)));
                // The bias beat has no matching input word, so the data RAM stays idle.
                if (beat_idx != LAST_BEAT) begin
                    o_data_rd   = 1'b1;
                    o_data_addr = beat_idx;
                end else begin
                    next_state  = DRAIN;
                end
            end
            DRAIN: begin
                o_busy     = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                o_busy = 1'b1;
                if (i_node_valid) next_state = WRITE;
            end
            WRITE: begin
                o_busy        = 1'b1;
                o_result_we   = 1'b1;
                o_result_addr = node_idx;
                o_result_data = result_q;
                next_state    = (node_idx == LAST_NODE) ? DONE : LOAD;
            end
            DONE: begin
                o_done     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_idx     <= '0;
            beat_idx     <= '0;
            beat_valid_d <= 1'b0;
            input_beat_d <= 1'b0;
            result_q     <= '0;
            error_q      <= 1'b0;
        end else begin
            beat_valid_d <= o_weight_rd;
            input_beat_d <= o_data_rd;
            error_q      <= i_node_valid && (state != WAIT);
            case (state)
                IDLE: begin
                    if (i_start) begin
                        node_idx <= '0;
                        beat_idx <= '0;
                    end
                end
                LOAD: begin
                    if (beat_idx != LAST_BEAT) beat_idx <= beat_idx + 1'b1;
                end
                WAIT: begin
                    if (i_node_valid) result_q <= i_node_data;
                end
                WRITE: begin
                    if (node_idx != LAST_NODE) begin
                        node_idx <= node_idx + 1'b1;
                        beat_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM words arrive one cycle after the read, aligned with the delayed strobes.
    assign o_node_valid  = beat_valid_d;
    assign o_node_weight = beat_valid_d ? i_weight_ram : FP_ZERO;
    assign o_node_data   = input_beat_d ? i_data_ram : FP_ZERO;
    assign o_error       = error_q;

endmodule

// File: tb/tb_feed_forward_layer_controller.sv
// tb/tb_feed_forward_layer_controller.sv - directed self-checking bench for the layer controller
module tb_feed_forward_layer_controller;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        o_busy, o_done, o_error;
    logic        o_data_rd, o_weight_rd, o_node_valid, o_result_we;
    logic [4:0]  o_data_addr, o_weight_addr, o_result_addr;
    logic [31:0] i_data_ram, i_weight_ram;
    logic [31:0] o_node_data, o_node_weight, o_result_data;
    logic        i_node_valid;
    logic [31:0] i_node_data;

    logic        model_valid;
    logic [31:0] model_data;
    logic        inj_valid;
    logic [31:0] inj_data;
    int          lat;

    logic [31:0] data_mem   [32];
    logic [31:0] weight_mem [32];
    logic [31:0] exp_res    [4];

    int cyc;
    int checks;
    int errors;

    logic [4:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_cyc  [$];
    logic [31:0] bt_data [$];
    logic [31:0] bt_w    [$];
    int          bt_cyc  [$];
    logic [4:0]  base_q  [$];
    int          done_n;
    int          done_cyc;
    logic        done_busy;
    int          err_n;
    logic        prev_wrd;

    feed_forward_layer_controller #(
        .DATA_WIDTH(32),
        .ADDRESS_WIDTH(5),
        .NUMBER_OF_INPUT_NODE(2),
        .NUMBER_OF_OUTPUT_NODE(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_start(i_start),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_error(o_error),
        .o_data_rd(o_data_rd),
        .o_data_addr(o_data_addr),
        .i_data_ram(i_data_ram),
        .o_weight_rd(o_weight_rd),
        .o_weight_addr(o_weight_addr),
        .i_weight_ram(i_weight_ram),
        .o_node_valid(o_node_valid),
        .o_node_data(o_node_data),
        .o_node_weight(o_node_weight),
        .i_node_valid(i_node_valid),
        .i_node_data(i_node_data),
        .o_result_we(o_result_we),
        .o_result_addr(o_result_addr),
        .o_result_data(o_result_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign i_node_valid = model_valid | inj_valid;
    assign i_node_data  = model_valid ? model_data : inj_data;

    always @(posedge clk) begin
        if (o_data_rd)   i_data_ram   <= data_mem[o_data_addr];
        if (o_weight_rd) i_weight_ram <= weight_mem[o_weight_addr];
    end

    // Node model: answers lat cycles after its last beat; result keyed by first weight.
    int          beat_cnt = 0;
    int          pend = 0;
    logic [31:0] first_w = 32'h0;
    initial begin
        model_valid = 1'b0;
        model_data  = 32'h0;
    end
    always @(negedge clk) begin
        model_valid = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                model_valid = 1'b1;
                model_data  = (first_w == 32'h3F80_0000) ? 32'h4060_0000 : first_w + 32'h0010_0000;
            end
        end
        if (o_node_valid) begin
            if (beat_cnt == 0) first_w = o_node_weight;
            beat_cnt = beat_cnt + 1;
            if (beat_cnt == 3) begin
                beat_cnt = 0;
                pend     = lat + 1;
            end
        end
    end

    initial begin
        done_n = 0; done_cyc = 0; done_busy = 1'b0; err_n = 0; prev_wrd = 1'b0;
    end
    always @(negedge clk) begin
        if (o_result_we) begin
            wr_addr.push_back(o_result_addr);
            wr_data.push_back(o_result_data);
            wr_cyc.push_back(cyc);
        end
        if (o_done) begin
            done_n    = done_n + 1;
            done_cyc  = cyc;
            done_busy = o_busy;
        end
        if (o_error) err_n = err_n + 1;
        if (o_node_valid) begin
            bt_data.push_back(o_node_data);
            bt_w.push_back(o_node_weight);
            bt_cyc.push_back(cyc);
        end
        if (o_weight_rd && !prev_wrd) base_q.push_back(o_weight_addr);
        prev_wrd = o_weight_rd;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, 64'({o_busy, o_done, o_error, o_data_rd, o_weight_rd, o_node_valid, o_result_we}), 64'h0);
        check({tag, "_addr"}, 64'({o_data_addr, o_weight_addr, o_result_addr}), 64'h0);
        check({tag, "_beat"}, {o_node_data, o_node_weight}, 64'h0);
        check({tag, "_res"}, 64'(o_result_data), 64'h0);
    endtask

    task automatic start_pass(output int s0);
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        s0 = cyc - 1;
    endtask

    task automatic wait_done(input int dn0, input int budget);
        int k;
        k = 0;
        while (done_n == dn0 && k < budget) begin
            @(negedge clk);
            k = k + 1;
        end
        check("done_timeout", 64'(done_n != dn0), 64'h1);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input int wb, input int s0,
                                input int first_rel, input int done_rel);
        check({tag, "_wr_count"}, 64'(wr_addr.size() - wb), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_wr_addr"}, 64'(wr_addr[wb + i]), 64'(i));
            check({tag, "_wr_data"}, 64'(wr_data[wb + i]), 64'(exp_res[i]));
        end
        check({tag, "_first_wr_cyc"}, 64'(wr_cyc[wb] - s0), 64'(first_rel));
        check({tag, "_done_cyc"}, 64'(done_cyc - s0), 64'(done_rel));
        check({tag, "_busy_at_done"}, 64'(done_busy), 64'h0);
    endtask

    int s0, wb, bb, gb, dn, en, k;

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; i_start = 1'b0; inj_valid = 1'b0; inj_data = 32'h0; lat = 20;
        for (int i = 0; i < 32; i++) begin
            data_mem[i]   = 32'h0;
            weight_mem[i] = 32'h0;
        end
        data_mem[0] = 32'h3F80_0000;
        data_mem[1] = 32'h4000_0000;
        weight_mem[0] = 32'h3F80_0000;
        weight_mem[1] = 32'h3F80_0000;
        weight_mem[2] = 32'h3F00_0000;
        for (int n = 1; n < 4; n++) begin
            weight_mem[n * 3]     = 32'h4100_0000 + 32'(n);
            weight_mem[n * 3 + 1] = 32'h3F80_0000;
            weight_mem[n * 3 + 2] = 32'h3E80_0000;
        end
        exp_res[0] = 32'h4060_0000;
        exp_res[1] = 32'h4110_0001;
        exp_res[2] = 32'h4110_0002;
        exp_res[3] = 32'h4110_0003;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("idle");

        // Pass A: long node latency, spurious start mid-pass.
        wb = wr_addr.size(); bb = bt_cyc.size(); gb = base_q.size(); dn = done_n; en = err_n;
        start_pass(s0);
        check("a_busy_rel1", 64'({o_busy, o_weight_rd, o_data_rd}), 64'h7);
        check("a_addr_rel1", 64'({o_weight_addr, o_data_addr}), 64'h0);
        repeat (10) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(dn, 400);
        check("a_beat0", {bt_data[bb], bt_w[bb]}, 64'h3F80_0000_3F80_0000);
        check("a_beat1", {bt_data[bb + 1], bt_w[bb + 1]}, 64'h4000_0000_3F80_0000);
        check("a_beat2", {bt_data[bb + 2], bt_w[bb + 2]}, 64'h0000_0000_3F00_0000);
        check("a_beat_cycles", {32'(bt_cyc[bb] - s0), 16'(bt_cyc[bb + 1] - s0), 16'(bt_cyc[bb + 2] - s0)},
              {32'd2, 16'd3, 16'd4});
        check("a_beat_count", 64'(bt_cyc.size() - bb), 64'd12);
        for (int i = 0; i < 4; i++) check("a_weight_base", 64'(base_q[gb + i]), 64'(i * 3));
        check_writes("a", wb, s0, 26, 105);
        check("a_done_count", 64'(done_n - dn), 64'd1);
        check("a_no_error", 64'(err_n - en), 64'd0);

        // Pass B: zero-latency node, stray result injected during LOAD.
        lat = 0;
        wb = wr_addr.size(); bb = bt_cyc.size(); dn = done_n; en = err_n;
        start_pass(s0);
        inj_valid = 1'b1;
        inj_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        inj_valid = 1'b0;
        wait_done(dn, 200);
        check("b_error_count", 64'(err_n - en), 64'd1);
        check("b_beat_count", 64'(bt_cyc.size() - bb), 64'd12);
        check_writes("b", wb, s0, 6, 25);
        check("b_done_count", 64'(done_n - dn), 64'd1);

        // Pass C: reset while node 1 is waiting, then a clean pass.
        lat = 20;
        wb = wr_addr.size(); dn = done_n; en = err_n;
        start_pass(s0);
        k = 0;
        while ((cyc - s0) < 40 && k < 100) begin
            @(negedge clk);
            k = k + 1;
        end
        check("c_reach_wait", 64'(cyc - s0), 64'd40);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("c_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("c_wr_count", 64'(wr_addr.size() - wb), 64'd1);
        check("c_wr0", {32'(wr_addr[wb]), wr_data[wb]}, {32'd0, 32'h4060_0000});
        check("c_no_done", 64'(done_n - dn), 64'd0);
        check("c_late_error", 64'(err_n - en), 64'd1);
        lat = 0;
        wb = wr_addr.size(); gb = base_q.size(); dn = done_n; en = err_n;
        start_pass(s0);
        wait_done(dn, 200);
        check("c_restart_base", 64'(base_q[gb]), 64'd0);
        check_writes("c", wb, s0, 6, 25);
        check("c_done_count", 64'(done_n - dn), 64'd1);
        check("c_no_error", 64'(err_n - en), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
